// File: rtl/reservation_station.sv
// Integer-ALU reservation station: allocates renamed rf instructions, snoops ALU/SLB buses, dispatches one ready entry per cycle.
// Optional macro RS_CDB_BYPASS_EN: dispatch selection sees operands woken by the buses in the same cycle.
module reservation_station #(
   parameter int RsSize    = 16,
   parameter int DataWidth = 32,
   parameter int PcWidth   = 32,
   parameter int OpWidth   = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 is_exception_from_rob,
   input  logic                 is_ready_from_rf,
   input  logic                 is_empty_from_rf,
   input  logic                 is_sl_from_rf,
   input  logic [DataWidth-1:0] v1_from_rf,
   input  logic [DataWidth-1:0] v2_from_rf,
   input  logic [PcWidth-1:0]   q1_from_rf,
   input  logic [PcWidth-1:0]   q2_from_rf,
   input  logic [DataWidth-1:0] imm_from_rf,
   input  logic [OpWidth-1:0]   op_from_rf,
   input  logic [PcWidth-1:0]   pc_from_rf,
   input  logic                 is_valid_from_alu,
   input  logic [PcWidth-1:0]   pc_from_alu,
   input  logic [DataWidth-1:0] data_from_alu,
   input  logic                 is_valid_from_slb,
   input  logic [PcWidth-1:0]   pc_from_slb,
   input  logic [DataWidth-1:0] data_from_slb,
   output logic                 is_ready_to_rf,
   output logic                 is_valid_to_alu,
   output logic [OpWidth-1:0]   op_to_alu,
   output logic [DataWidth-1:0] v1_to_alu,
   output logic [DataWidth-1:0] v2_to_alu,
   output logic [DataWidth-1:0] imm_to_alu,
   output logic [PcWidth-1:0]   pc_to_alu
);
   localparam int IdxW = $clog2(RsSize);
   localparam int CntW = IdxW + 1;

   logic [RsSize-1:0]    valid;
   logic [DataWidth-1:0] ent_v1  [RsSize];
   logic [DataWidth-1:0] ent_v2  [RsSize];
   logic [DataWidth-1:0] ent_imm [RsSize];
   logic [PcWidth-1:0]   ent_q1  [RsSize];
   logic [PcWidth-1:0]   ent_q2  [RsSize];
   logic [PcWidth-1:0]   ent_pc  [RsSize];
   logic [OpWidth-1:0]   ent_op  [RsSize];

   logic [DataWidth-1:0] wake_v1 [RsSize];
   logic [DataWidth-1:0] wake_v2 [RsSize];
   logic [PcWidth-1:0]   wake_q1 [RsSize];
   logic [PcWidth-1:0]   wake_q2 [RsSize];
   logic [DataWidth-1:0] new_v1, new_v2;
   logic [PcWidth-1:0]   new_q1, new_q2;
   logic                 alloc_req, alloc_found, alloc_fire, disp_found;
   logic [IdxW-1:0]      alloc_idx, disp_idx;
   logic [RsSize-1:0]    valid_next;
   logic [CntW-1:0]      free_cnt;

   // A waiting operand takes the bus value on a tag match; ALU beats SLB, and q==0 never matches.
   function automatic logic [DataWidth+PcWidth-1:0] snoop(
      input logic [PcWidth-1:0]   q,
      input logic [DataWidth-1:0] v,
      input logic                 alu_vld,
      input logic [PcWidth-1:0]   alu_pc,
      input logic [DataWidth-1:0] alu_data,
      input logic                 slb_vld,
      input logic [PcWidth-1:0]   slb_pc,
      input logic [DataWidth-1:0] slb_data
   );
      if (q != '0 && alu_vld && alu_pc == q) return {alu_data, {PcWidth{1'b0}}};
      if (q != '0 && slb_vld && slb_pc == q) return {slb_data, {PcWidth{1'b0}}};
      return {v, q};
   endfunction

   always_comb begin
      alloc_req   = is_ready_from_rf && !is_empty_from_rf && !is_sl_from_rf;
      alloc_found = 1'b0;
      alloc_idx   = '0;
      disp_found  = 1'b0;
      disp_idx    = '0;
      {new_v1, new_q1} = snoop(q1_from_rf, v1_from_rf, is_valid_from_alu, pc_from_alu, data_from_alu,
                               is_valid_from_slb, pc_from_slb, data_from_slb);
      {new_v2, new_q2} = snoop(q2_from_rf, v2_from_rf, is_valid_from_alu, pc_from_alu, data_from_alu,
                               is_valid_from_slb, pc_from_slb, data_from_slb);
      for (int i = 0; i < RsSize; i++) begin
         {wake_v1[i], wake_q1[i]} = snoop(ent_q1[i], ent_v1[i], is_valid_from_alu, pc_from_alu, data_from_alu,
                                          is_valid_from_slb, pc_from_slb, data_from_slb);
         {wake_v2[i], wake_q2[i]} = snoop(ent_q2[i], ent_v2[i], is_valid_from_alu, pc_from_alu, data_from_alu,
                                          is_valid_from_slb, pc_from_slb, data_from_slb);
         if (!alloc_found && !valid[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IdxW'(i);
         end
`ifdef RS_CDB_BYPASS_EN
         if (!disp_found && valid[i] && wake_q1[i] == '0 && wake_q2[i] == '0) begin
`else
         if (!disp_found && valid[i] && ent_q1[i] == '0 && ent_q2[i] == '0) begin
`endif
            disp_found = 1'b1;
            disp_idx   = IdxW'(i);
         end
      end
      alloc_fire = alloc_req && alloc_found;
      valid_next = valid;
      if (disp_found) valid_next[disp_idx] = 1'b0;
      if (alloc_fire) valid_next[alloc_idx] = 1'b1;
      free_cnt = '0;
      for (int i = 0; i < RsSize; i++)
         if (!valid_next[i]) free_cnt = free_cnt + CntW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid           <= '0;
         is_ready_to_rf  <= 1'b1;
         is_valid_to_alu <= 1'b0;
         op_to_alu       <= '0;
         v1_to_alu       <= '0;
         v2_to_alu       <= '0;
         imm_to_alu      <= '0;
         pc_to_alu       <= '0;
      end else if (is_exception_from_rob) begin
         valid           <= '0;
         is_ready_to_rf  <= 1'b1;
         is_valid_to_alu <= 1'b0;
      end else begin
         valid           <= valid_next;
         is_ready_to_rf  <= free_cnt >= CntW'(2);
         is_valid_to_alu <= disp_found;
         if (disp_found) begin
            op_to_alu  <= ent_op[disp_idx];
            v1_to_alu  <= wake_v1[disp_idx];
            v2_to_alu  <= wake_v2[disp_idx];
            imm_to_alu <= ent_imm[disp_idx];
            pc_to_alu  <= ent_pc[disp_idx];
         end
      end
   end

   // Entry payload carries no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RsSize; i++) begin
         if (alloc_fire && alloc_idx == IdxW'(i)) begin
            ent_v1[i]  <= new_v1;
            ent_v2[i]  <= new_v2;
            ent_q1[i]  <= new_q1;
            ent_q2[i]  <= new_q2;
            ent_imm[i] <= imm_from_rf;
            ent_op[i]  <= op_from_rf;
            ent_pc[i]  <= pc_from_rf;
         end else begin
            ent_v1[i]  <= wake_v1[i];
            ent_v2[i]  <= wake_v2[i];
            ent_q1[i]  <= wake_q1[i];
            ent_q2[i]  <= wake_q2[i];
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios with literal expectations plus random traffic against a behavioural model.
module tb_reservation_station;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        exc = 1'b0, rf_rdy = 1'b0, rf_empty = 1'b0, rf_sl = 1'b0;
   logic [31:0] rf_v1 = '0, rf_v2 = '0, rf_q1 = '0, rf_q2 = '0, rf_imm = '0, rf_pc = '0;
   logic [5:0]  rf_op = '0;
   logic        alu_v = 1'b0, slb_v = 1'b0;
   logic [31:0] alu_pc = '0, alu_d = '0, slb_pc = '0, slb_d = '0;
   logic        rdy_o, vld_o;
   logic [5:0]  op_o;
   logic [31:0] v1_o, v2_o, imm_o, pc_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   reservation_station dut (
      .clk(clk), .rst(rst), .is_exception_from_rob(exc),
      .is_ready_from_rf(rf_rdy), .is_empty_from_rf(rf_empty), .is_sl_from_rf(rf_sl),
      .v1_from_rf(rf_v1), .v2_from_rf(rf_v2), .q1_from_rf(rf_q1), .q2_from_rf(rf_q2),
      .imm_from_rf(rf_imm), .op_from_rf(rf_op), .pc_from_rf(rf_pc),
      .is_valid_from_alu(alu_v), .pc_from_alu(alu_pc), .data_from_alu(alu_d),
      .is_valid_from_slb(slb_v), .pc_from_slb(slb_pc), .data_from_slb(slb_d),
      .is_ready_to_rf(rdy_o), .is_valid_to_alu(vld_o), .op_to_alu(op_o),
      .v1_to_alu(v1_o), .v2_to_alu(v2_o), .imm_to_alu(imm_o), .pc_to_alu(pc_o)
   );

   typedef struct {
      bit          vld;
      logic [31:0] v1, v2, q1, q2, imm, pc;
      logic [5:0]  op;
   } ent_t;

   ent_t        m [16];
   bit          e_vld = 1'b0, e_rdy = 1'b1;
   logic [5:0]  e_op = '0;
   logic [31:0] e_v1 = '0, e_v2 = '0, e_imm = '0, e_pc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Operand after seeing this cycle's buses: {value, tag}.
   function automatic logic [63:0] wake(input logic [31:0] q, input logic [31:0] v);
      if (q != 0 && alu_v && alu_pc == q) return {alu_d, 32'h0};
      if (q != 0 && slb_v && slb_pc == q) return {slb_d, 32'h0};
      return {v, q};
   endfunction

   task automatic model_step();
      ent_t w [16];
      int   di, ai, free;
      bit   bypass;
`ifdef RS_CDB_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      if (exc) begin
         for (int i = 0; i < 16; i++) m[i].vld = 1'b0;
         e_vld = 1'b0;
         e_rdy = 1'b1;
         return;
      end
      for (int i = 0; i < 16; i++) begin
         w[i] = m[i];
         {w[i].v1, w[i].q1} = wake(m[i].q1, m[i].v1);
         {w[i].v2, w[i].q2} = wake(m[i].q2, m[i].v2);
      end
      di = -1;
      for (int i = 0; i < 16 && di < 0; i++)
         if (m[i].vld && (bypass ? (w[i].q1 == 0 && w[i].q2 == 0) : (m[i].q1 == 0 && m[i].q2 == 0)))
            di = i;
      e_vld = (di >= 0);
      if (di >= 0) begin
         e_op = w[di].op; e_v1 = w[di].v1; e_v2 = w[di].v2; e_imm = w[di].imm; e_pc = w[di].pc;
         w[di].vld = 1'b0;
      end
      if (rf_rdy && !rf_empty && !rf_sl) begin
         ai = -1;
         for (int i = 0; i < 16 && ai < 0; i++) if (!m[i].vld) ai = i;
         if (ai >= 0) begin
            w[ai].vld = 1'b1;
            {w[ai].v1, w[ai].q1} = wake(rf_q1, rf_v1);
            {w[ai].v2, w[ai].q2} = wake(rf_q2, rf_v2);
            w[ai].imm = rf_imm; w[ai].op = rf_op; w[ai].pc = rf_pc;
         end
      end
      free = 0;
      for (int i = 0; i < 16; i++) begin
         m[i] = w[i];
         if (!w[i].vld) free++;
      end
      e_rdy = (free >= 2);
   endtask

   task automatic compare();
      chk("valid", 32'(vld_o), 32'(e_vld));
      chk("ready", 32'(rdy_o), 32'(e_rdy));
      chk("op", 32'(op_o), 32'(e_op));
      chk("v1", v1_o, e_v1);
      chk("v2", v2_o, e_v2);
      chk("imm", imm_o, e_imm);
      chk("pc", pc_o, e_pc);
   endtask

   // Inputs are set between negedge and posedge; the model steps on the edge, outputs are checked at negedge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      exc = 1'b0; rf_rdy = 1'b0; rf_sl = 1'b0; rf_empty = 1'b0; alu_v = 1'b0; slb_v = 1'b0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] q1, input logic [31:0] q2,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [5:0] op);
      rf_rdy = 1'b1; rf_pc = pc; rf_q1 = q1; rf_q2 = q2; rf_v1 = v1; rf_v2 = v2; rf_op = op;
      rf_imm = pc ^ 32'h5A5A;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] next_pc;
      bit          bypass;
`ifdef RS_CDB_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      for (int i = 0; i < 16; i++) m[i].vld = 1'b0;
      #12;
      chk("reset_valid", 32'(vld_o), 32'd0);
      chk("reset_ready", 32'(rdy_o), 32'd1);
      chk("reset_pc", pc_o, 32'd0);
      chk("reset_v1", v1_o, 32'd0);
      rst = 1'b1;

      // Ready instruction dispatches one cycle after allocation, once only.
      issue(32'h10, 0, 0, 5, 7, 6'd3);
      cycle();
      chk("t1_not_yet", 32'(vld_o), 32'd0);
      cycle();
      chk("t1_valid", 32'(vld_o), 32'd1);
      chk("t1_pc", pc_o, 32'h10);
      chk("t1_v1", v1_o, 32'd5);
      chk("t1_v2", v2_o, 32'd7);
      chk("t1_op", 32'(op_o), 32'd3);
      cycle();
      chk("t1_once", 32'(vld_o), 32'd0);

      // Wakeup from the ALU bus.
      issue(32'h20, 32'h14, 0, 0, 32'h1, 6'd4);
      cycle();
      cycle();
      cycle();
      alu_v = 1'b1; alu_pc = 32'h14; alu_d = 32'hAB;
      cycle();
      if (!bypass) begin
         chk("t2_wait", 32'(vld_o), 32'd0);
         cycle();
      end
      chk("t2_valid", 32'(vld_o), 32'd1);
      chk("t2_pc", pc_o, 32'h20);
      chk("t2_v1", v1_o, 32'hAB);

      // Fill 15 entries on tag 0x99, then drain via the SLB bus.
      for (int k = 0; k < 15; k++) begin
         issue(32'h100 + 32'(4 * k), 32'h99, 0, 0, 32'(k), 6'(k));
         cycle();
         if (k == 13) chk("t3_ready_14", 32'(rdy_o), 32'd1);
         if (k == 14) chk("t3_ready_15", 32'(rdy_o), 32'd0);
      end
      slb_v = 1'b1; slb_pc = 32'h99; slb_d = 32'h1234;
      cycle();
      for (int k = 0; k < 15; k++) begin
         if (k > 0 || !bypass) cycle();
         chk("t3_order", pc_o, 32'h100 + 32'(4 * k));
         chk("t3_valid", 32'(vld_o), 32'd1);
         chk("t3_v1", v1_o, 32'h1234);
      end
      chk("t3_ready_back", 32'(rdy_o), 32'd1);
      cycle();
      chk("t3_drained", 32'(vld_o), 32'd0);

      // Same-cycle capture of an ALU broadcast at allocation.
      issue(32'h30, 0, 32'h2C, 32'h3, 0, 6'd9);
      alu_v = 1'b1; alu_pc = 32'h2C; alu_d = 32'd9;
      cycle();
      cycle();
      chk("t4_valid", 32'(vld_o), 32'd1);
      chk("t4_pc", pc_o, 32'h30);
      chk("t4_v2", v2_o, 32'd9);

      // Exception flushes waiting entries and the concurrent issue.
      for (int k = 0; k < 5; k++) begin
         issue(32'h200 + 32'(4 * k), 32'h77, 0, 0, 0, 6'd1);
         cycle();
      end
      issue(32'h300, 0, 0, 1, 2, 6'd2);
      exc = 1'b1;
      cycle();
      chk("t5_ready", 32'(rdy_o), 32'd1);
      chk("t5_valid", 32'(vld_o), 32'd0);
      alu_v = 1'b1; alu_pc = 32'h77; alu_d = 32'h55;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("t5_no_disp", 32'(vld_o), 32'd0);
      end

      // Load/store instructions are ignored.
      issue(32'h400, 0, 0, 1, 1, 6'd1);
      rf_sl = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("t6_no_disp", 32'(vld_o), 32'd0);
      end

      // Random traffic against the model.
      next_pc = 32'h1000;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 60 && (rdy_o || $urandom_range(0, 7) == 0)) begin
            issue(next_pc,
                  ($urandom_range(0, 1) == 0) ? 32'h0 : next_pc - 32'(4 * $urandom_range(1, 6)),
                  ($urandom_range(0, 2) == 0) ? 32'h0 : next_pc - 32'(4 * $urandom_range(1, 6)),
                  $urandom, $urandom, 6'($urandom));
            rf_empty = ($urandom_range(0, 9) == 0);
            rf_sl    = ($urandom_range(0, 9) == 0);
            next_pc  = next_pc + 4;
         end
         alu_v  = ($urandom_range(0, 1) == 0);
         alu_pc = ($urandom_range(0, 9) == 0) ? 32'h0 : next_pc - 32'(4 * $urandom_range(0, 8));
         alu_d  = $urandom;
         slb_v  = ($urandom_range(0, 2) == 0);
         slb_pc = ($urandom_range(0, 3) == 0) ? alu_pc : next_pc - 32'(4 * $urandom_range(0, 8));
         slb_d  = $urandom;
         exc    = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
